mem_op_sequencer: RTL and testbench

- Parametrised control sequencer that replaces hand-driven T-step control for memory instructions (ld, ldi, st).
- Sits beside Datapath and drives its bus-out/bus-in enables, select-and-encode strobes and memory read/write lines.
- Adds a memory ready handshake with variable wait states, opcode decode, and error reporting. None of these exist in fixed-timing stepping.

---
 rtl/memseq_pkg.sv | 45 ++++
 rtl/memseq_wait_ctr.sv | 46 ++++
 rtl/mem_op_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_mem_op_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memseq_pkg.sv
// =============================================================================
// Package  : memseq_pkg
// Purpose  : Shared types and constants for the memory-instruction sequencer.
//            Holds the FSM state enumeration (4-bit encoding), the default
//            opcode values for ld/ldi/st, the ALU add code, the default
//            wait-state limits and a small state-classification helper.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package memseq_pkg;

  // Default configuration values; the top module exposes these as parameters.
  localparam int         c_OPCODE_W = 5;
  localparam logic [4:0] c_OP_LD    = 5'b00000;
  localparam logic [4:0] c_OP_LDI   = 5'b00001;
  localparam logic [4:0] c_OP_ST    = 5'b00010;
  localparam logic [4:0] c_ALU_ADD  = 5'b00011;
  localparam int         c_MAX_WAIT = 15;
  localparam int         c_WAIT_W   = 4;

  // Sequencer states. The encoding is visible on state_dbg, so keep it stable.
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T1W  = 4'd3,
    T2   = 4'd4,
    T3   = 4'd5,
    T4   = 4'd6,
    T5   = 4'd7,
    T6   = 4'd8,
    T7   = 4'd9,
    DONE = 4'd10,
    ERR  = 4'd11
  } state_t;

  // The sequencer counts as busy everywhere except the two resting states.
  function automatic logic state_is_busy(input state_t s);
    return !((s == IDLE) || (s == ERR));
  endfunction

endpackage : memseq_pkg

`default_nettype wire

// File: rtl/memseq_wait_ctr.sv
// =============================================================================
// Module   : memseq_wait_ctr
// Purpose  : Wait-state counter for the memory handshake. Synchronous clear
//            has priority over increment; the count saturates at MAX_WAIT and
//            o_at_max flags the saturated value. One instance serves all wait
//            points of the sequencer.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            i_clear   - clear count to zero on the next edge
//            i_inc     - increment count (ignored once saturated)
//            o_at_max  - count equals MAX_WAIT
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module memseq_wait_ctr #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_at_max
);

  localparam logic [WAIT_W-1:0] c_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] c_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != c_MAX)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_at_max = (r_count == c_MAX);

endmodule : memseq_wait_ctr

`default_nettype wire

// File: rtl/mem_op_sequencer.sv
// =============================================================================
// Module   : mem_op_sequencer
// Purpose  : Control sequencer for memory instructions (ld, ldi, st). Steps
//            the datapath through fetch (T0-T2) and execute (T3-T7), waits on
//            mem_ready for memory reads/writes, decodes the opcode and flags
//            illegal opcodes and (optionally) memory timeouts.
// Ports    : clk, clr (async active-high reset), start, ir_opcode, mem_ready
//            -> bus-out enables  pc_out zlo_out mdr_out r_out c_out ba_out
//            -> load enables     mar_in zlo_in pc_in mdr_in ir_in y_in r_in
//            -> strobes          inc_pc read write gra grb, alu_op
//            -> status           busy done err_illegal err_timeout state_dbg
// Config   : `define MEMSEQ_TIMEOUT_EN to abort to ERR (raising err_timeout)
//            when mem_ready stays low for MAX_WAIT wait cycles. Without it the
//            sequencer waits indefinitely and err_timeout is tied low.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_op_sequencer
  import memseq_pkg::*;
#(
  parameter int                  OPCODE_W = c_OPCODE_W,
  parameter logic [OPCODE_W-1:0] OP_LD    = OPCODE_W'(c_OP_LD),
  parameter logic [OPCODE_W-1:0] OP_LDI   = OPCODE_W'(c_OP_LDI),
  parameter logic [OPCODE_W-1:0] OP_ST    = OPCODE_W'(c_OP_ST),
  parameter logic [4:0]          ALU_ADD  = c_ALU_ADD,
  parameter int                  MAX_WAIT = c_MAX_WAIT,
  parameter int                  WAIT_W   = c_WAIT_W
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                mem_ready,
  output logic                pc_out,
  output logic                zlo_out,
  output logic                mdr_out,
  output logic                r_out,
  output logic                c_out,
  output logic                ba_out,
  output logic                mar_in,
  output logic                zlo_in,
  output logic                pc_in,
  output logic                mdr_in,
  output logic                ir_in,
  output logic                y_in,
  output logic                r_in,
  output logic                inc_pc,
  output logic                read,
  output logic                write,
  output logic                gra,
  output logic                grb,
  output logic [4:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                err_illegal,
  output logic                err_timeout,
  output logic [3:0]          state_dbg
);

`ifdef MEMSEQ_TIMEOUT_EN
  localparam logic c_TIMEOUT_EN = 1'b1;
`else
  localparam logic c_TIMEOUT_EN = 1'b0;
`endif

  state_t              r_state;
  state_t              w_next_state;
  logic [OPCODE_W-1:0] r_op_q;
  logic                r_err_illegal;
  logic                r_err_timeout;

  logic w_t3_legal;
  logic w_is_ld;
  logic w_is_ldi;
  logic w_is_st;
  logic w_start_accept;
  logic w_in_wait;
  logic w_wait_clear;
  logic w_wait_inc;
  logic w_at_max;
  logic w_timeout;

  // IR loads on the T2->T3 edge, so the opcode field is only valid during
  // T3 itself. T3 therefore decodes the live field; op_q captures it at the
  // end of T3 and steers T4..T7.
  assign w_t3_legal = (ir_opcode == OP_LD) || (ir_opcode == OP_LDI) ||
                      (ir_opcode == OP_ST);

  assign w_is_ld  = (r_op_q == OP_LD);
  assign w_is_ldi = (r_op_q == OP_LDI);
  assign w_is_st  = (r_op_q == OP_ST);

  assign w_start_accept = start && ((r_state == IDLE) || (r_state == ERR));

  // States in which the sequencer is waiting on mem_ready.
  assign w_in_wait = (r_state == T1) || (r_state == T1W) ||
                     ((r_state == T6) && w_is_ld) ||
                     ((r_state == T7) && w_is_st);

  // Clear on the edge that enters a wait-capable state: T0->T1, T5->T6
  // (harmless for ldi, which never waits there) and st T6->T7.
  assign w_wait_clear = (r_state == T0) || (r_state == T5) ||
                        ((r_state == T6) && w_is_st);
  assign w_wait_inc   = w_in_wait && !mem_ready;

  memseq_wait_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_ctr (
    .clk      (clk),
    .rst      (clr),
    .i_clear  (w_wait_clear),
    .i_inc    (w_wait_inc),
    .o_at_max (w_at_max)
  );

  assign w_timeout = c_TIMEOUT_EN && w_in_wait && !mem_ready && w_at_max;

  // ---------------------------------------------------------------------------
  // State register and opcode latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_op_q <= '0;
    end else if (r_state == T3) begin
      r_op_q <= ir_opcode;
    end
  end

  // Sticky error flags; an accepted start clears both before the new run.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else if (w_start_accept) begin
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if ((r_state == T3) && !w_t3_legal) begin
        r_err_illegal <= 1'b1;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (start) w_next_state = T0;
      T0:   w_next_state = T1;
      T1: begin
        if (mem_ready)      w_next_state = T2;
        else if (w_timeout) w_next_state = ERR;
        else                w_next_state = T1W;
      end
      T1W: begin
        if (mem_ready)      w_next_state = T2;
        else if (w_timeout) w_next_state = ERR;
      end
      T2:   w_next_state = T3;
      T3:   w_next_state = w_t3_legal ? T4 : ERR;
      T4:   w_next_state = T5;
      T5:   w_next_state = w_is_ldi ? DONE : T6;
      T6: begin
        if (!w_is_ld)       w_next_state = T7;
        else if (mem_ready) w_next_state = T7;
        else if (w_timeout) w_next_state = ERR;
      end
      T7: begin
        if (!w_is_st)       w_next_state = DONE;
        else if (mem_ready) w_next_state = DONE;
        else if (w_timeout) w_next_state = ERR;
      end
      DONE: w_next_state = IDLE;
      ERR:  if (start) w_next_state = T0;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (from the state register; T3 also looks at the live opcode)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_out  = 1'b0;
    zlo_out = 1'b0;
    mdr_out = 1'b0;
    r_out   = 1'b0;
    c_out   = 1'b0;
    ba_out  = 1'b0;
    mar_in  = 1'b0;
    zlo_in  = 1'b0;
    pc_in   = 1'b0;
    mdr_in  = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    r_in    = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    gra     = 1'b0;
    grb     = 1'b0;
    alu_op  = 5'b00000;
    done    = 1'b0;
    case (r_state)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        zlo_in = 1'b1;
      end
      T1: begin
        zlo_out = 1'b1;
        pc_in   = 1'b1;
        read    = 1'b1;
        mdr_in  = 1'b1;
      end
      T1W: begin
        read   = 1'b1;
        mdr_in = 1'b1;
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T3: begin
        if (w_t3_legal) begin
          grb    = 1'b1;
          ba_out = 1'b1;
          r_out  = 1'b1;
          y_in   = 1'b1;
        end
      end
      T4: begin
        c_out  = 1'b1;
        zlo_in = 1'b1;
        alu_op = ALU_ADD;
      end
      T5: begin
        zlo_out = 1'b1;
        if (w_is_ldi) begin
          gra  = 1'b1;
          r_in = 1'b1;
        end else begin
          mar_in = 1'b1;
        end
      end
      T6: begin
        mdr_in = 1'b1;
        if (w_is_ld) begin
          read = 1'b1;
        end else begin
          gra   = 1'b1;
          r_out = 1'b1;
        end
      end
      T7: begin
        if (w_is_ld) begin
          mdr_out = 1'b1;
          gra     = 1'b1;
          r_in    = 1'b1;
        end else begin
          write = 1'b1;
        end
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy        = state_is_busy(r_state);
  assign err_illegal = r_err_illegal;
  assign err_timeout = c_TIMEOUT_EN ? r_err_timeout : 1'b0;
  assign state_dbg   = r_state;

endmodule : mem_op_sequencer

`default_nettype wire

// File: tb/tb_mem_op_sequencer.sv
// =============================================================================
// Module   : tb_mem_op_sequencer
// Purpose  : Self-checking bench for mem_op_sequencer. A table of
//            instructions is expanded into per-cycle expected records pushed
//            onto a queue; each record also carries the mem_ready/start values
//            to drive that cycle. Records are popped and compared as the DUT
//            steps. Hand-written sequences cover error recovery, the wait
//            timeout and an asynchronous reset during a store.
// Config   : honours MEMSEQ_TIMEOUT_EN to select the timeout expectations.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_op_sequencer;
  import memseq_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [4:0] ir_opcode;
  logic       mem_ready;
  logic       pc_out, zlo_out, mdr_out, r_out, c_out, ba_out;
  logic       mar_in, zlo_in, pc_in, mdr_in, ir_in, y_in, r_in;
  logic       inc_pc, read, write, gra, grb;
  logic [4:0] alu_op;
  logic       busy, done, err_illegal, err_timeout;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  mem_op_sequencer u_dut (
    .clk (clk), .clr (clr), .start (start), .ir_opcode (ir_opcode),
    .mem_ready (mem_ready),
    .pc_out (pc_out), .zlo_out (zlo_out), .mdr_out (mdr_out), .r_out (r_out),
    .c_out (c_out), .ba_out (ba_out),
    .mar_in (mar_in), .zlo_in (zlo_in), .pc_in (pc_in), .mdr_in (mdr_in),
    .ir_in (ir_in), .y_in (y_in), .r_in (r_in),
    .inc_pc (inc_pc), .read (read), .write (write), .gra (gra), .grb (grb),
    .alu_op (alu_op), .busy (busy), .done (done),
    .err_illegal (err_illegal), .err_timeout (err_timeout),
    .state_dbg (state_dbg)
  );

  // Control word: one bit per strobe, in a fixed order.
  logic [19:0] w_ctrl;
  assign w_ctrl = {pc_out, zlo_out, mdr_out, r_out, c_out, ba_out,
                   mar_in, zlo_in, pc_in, mdr_in, ir_in, y_in, r_in,
                   inc_pc, read, write, gra, grb, busy, done};

  localparam logic [19:0] M_PC_OUT  = 20'd1 << 19;
  localparam logic [19:0] M_ZLO_OUT = 20'd1 << 18;
  localparam logic [19:0] M_MDR_OUT = 20'd1 << 17;
  localparam logic [19:0] M_R_OUT   = 20'd1 << 16;
  localparam logic [19:0] M_C_OUT   = 20'd1 << 15;
  localparam logic [19:0] M_BA_OUT  = 20'd1 << 14;
  localparam logic [19:0] M_MAR_IN  = 20'd1 << 13;
  localparam logic [19:0] M_ZLO_IN  = 20'd1 << 12;
  localparam logic [19:0] M_PC_IN   = 20'd1 << 11;
  localparam logic [19:0] M_MDR_IN  = 20'd1 << 10;
  localparam logic [19:0] M_IR_IN   = 20'd1 << 9;
  localparam logic [19:0] M_Y_IN    = 20'd1 << 8;
  localparam logic [19:0] M_R_IN    = 20'd1 << 7;
  localparam logic [19:0] M_INC_PC  = 20'd1 << 6;
  localparam logic [19:0] M_READ    = 20'd1 << 5;
  localparam logic [19:0] M_WRITE   = 20'd1 << 4;
  localparam logic [19:0] M_GRA     = 20'd1 << 3;
  localparam logic [19:0] M_GRB     = 20'd1 << 2;
  localparam logic [19:0] M_BUSY    = 20'd1 << 1;
  localparam logic [19:0] M_DONE    = 20'd1 << 0;

  localparam logic [4:0] OPC_LD  = 5'b00000;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_ST  = 5'b00010;
  localparam logic [4:0] ADD_OP  = 5'b00011;

  typedef struct {
    bit         rdy;
    bit         st;
    logic [3:0] s;
    logic [19:0] c;
    logic [4:0] a;
  } rec_t;

  typedef struct {
    logic [4:0] op;
    int         w1;   // mem_ready-low cycles during the fetch read
    int         wm;   // mem_ready-low cycles at the execute read/write
    int         cyc;  // start cycle through DONE, inclusive
    bit         ill;
  } vec_t;

  rec_t sb[$];
  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int done_total = 0;

  always @(negedge clk) if (done) done_total <= done_total + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit rnd();
    return ($urandom_range(0, 1) != 0);
  endfunction

  task automatic push(input bit rdy, input bit st, input logic [3:0] s,
                      input logic [19:0] c, input logic [4:0] a);
    rec_t t;
    t.rdy = rdy; t.st = st; t.s = s; t.c = c; t.a = a;
    sb.push_back(t);
  endtask

  // Expand one instruction into its expected cycle-by-cycle trace. mem_ready
  // and start are randomised wherever they must have no effect.
  task automatic build(input logic [4:0] op, input int w1, input int wm);
    bit legal;
    legal = (op == OPC_LD) || (op == OPC_LDI) || (op == OPC_ST);
    push(rnd(), rnd(), T0, M_PC_OUT | M_MAR_IN | M_INC_PC | M_ZLO_IN | M_BUSY, 5'd0);
    if (w1 == 0) begin
      push(1'b1, rnd(), T1, M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN | M_BUSY, 5'd0);
    end else begin
      push(1'b0, rnd(), T1, M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN | M_BUSY, 5'd0);
      for (int i = 1; i < w1; i++) push(1'b0, rnd(), T1W, M_READ | M_MDR_IN | M_BUSY, 5'd0);
      push(1'b1, rnd(), T1W, M_READ | M_MDR_IN | M_BUSY, 5'd0);
    end
    push(rnd(), rnd(), T2, M_MDR_OUT | M_IR_IN | M_BUSY, 5'd0);
    if (!legal) begin
      push(rnd(), rnd(), T3, M_BUSY, 5'd0);
      push(rnd(), 1'b0, ERR, 20'd0, 5'd0);
      push(rnd(), 1'b0, ERR, 20'd0, 5'd0);
      return;
    end
    push(rnd(), rnd(), T3, M_GRB | M_BA_OUT | M_R_OUT | M_Y_IN | M_BUSY, 5'd0);
    push(rnd(), rnd(), T4, M_C_OUT | M_ZLO_IN | M_BUSY, ADD_OP);
    if (op == OPC_LDI) begin
      push(rnd(), rnd(), T5, M_ZLO_OUT | M_GRA | M_R_IN | M_BUSY, 5'd0);
    end else begin
      push(rnd(), rnd(), T5, M_ZLO_OUT | M_MAR_IN | M_BUSY, 5'd0);
      if (op == OPC_LD) begin
        for (int i = 0; i < wm; i++) push(1'b0, rnd(), T6, M_READ | M_MDR_IN | M_BUSY, 5'd0);
        push(1'b1, rnd(), T6, M_READ | M_MDR_IN | M_BUSY, 5'd0);
        push(rnd(), rnd(), T7, M_MDR_OUT | M_GRA | M_R_IN | M_BUSY, 5'd0);
      end else begin
        push(rnd(), rnd(), T6, M_GRA | M_R_OUT | M_MDR_IN | M_BUSY, 5'd0);
        for (int i = 0; i < wm; i++) push(1'b0, rnd(), T7, M_WRITE | M_BUSY, 5'd0);
        push(1'b1, rnd(), T7, M_WRITE | M_BUSY, 5'd0);
      end
    end
    push(rnd(), rnd(), DONE, M_DONE | M_BUSY, 5'd0);
    push(rnd(), 1'b0, IDLE, 20'd0, 5'd0);
  endtask

  // Start one instruction and compare every popped record against the DUT.
  task automatic run(input int vi, input logic [4:0] op, input int w1, input int wm,
                     output int done_at, output int done_cnt);
    rec_t t;
    int cyc;
    ir_opcode = op;
    build(op, w1, wm);
    start = 1'b1;
    mem_ready = rnd();
    @(posedge clk); #1;
    cyc = 1;
    done_at = 0;
    done_cnt = 0;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      mem_ready = t.rdy;
      start = t.st;
      cyc++;
      @(negedge clk);
      check($sformatf("trace v%0d c%0d", vi, cyc),
            {3'b000, state_dbg, alu_op, w_ctrl}, {3'b000, t.s, t.a, t.c});
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_at, done_cnt, n, d0;

    vecs[0] = '{OPC_ST,   0, 0, 10, 1'b0};
    vecs[1] = '{OPC_LD,   0, 3, 13, 1'b0};
    vecs[2] = '{OPC_LDI,  0, 0,  8, 1'b0};
    vecs[3] = '{OPC_LD,   2, 0, 12, 1'b0};
    vecs[4] = '{OPC_ST,   1, 2, 13, 1'b0};
    vecs[5] = '{OPC_LDI,  3, 0, 11, 1'b0};
    vecs[6] = '{5'b11111, 0, 0,  0, 1'b1};
    vecs[7] = '{OPC_LD,   1, 1, 12, 1'b0};
    vecs[8] = '{5'b00100, 2, 0,  0, 1'b1};

    clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir_opcode = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {3'b000, state_dbg, alu_op, w_ctrl}, 32'd0);
    check("reset_flags", 32'({err_illegal, err_timeout}), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run(i, vecs[i].op, vecs[i].w1, vecs[i].wm, done_at, done_cnt);
      check($sformatf("done_count v%0d", i), 32'(done_cnt), vecs[i].ill ? 32'd0 : 32'd1);
      if (!vecs[i].ill) check($sformatf("cycles v%0d", i), 32'(done_at), 32'(vecs[i].cyc));
      check($sformatf("err_illegal v%0d", i), 32'(err_illegal), 32'(vecs[i].ill));
      check($sformatf("err_timeout v%0d", i), 32'(err_timeout), 32'd0);
    end

    // Sitting in ERR after an illegal opcode; start must clear it and run.
    check("err_rest", 32'({err_illegal, busy, state_dbg}), 32'({1'b1, 1'b0, 4'd11}));
    ir_opcode = OPC_LDI;
    mem_ready = 1'b1;
    d0 = done_total;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_clear_t0", 32'({err_illegal, state_dbg}), 32'({1'b0, 4'd1}));
    n = 0;
    while (state_dbg != 4'd0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("recover_done", 32'(done_total - d0), 32'd1);

    // Memory never answers during the fetch read.
    ir_opcode = OPC_LD;
    mem_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t1w_read", 32'({state_dbg, read, mdr_in}), 32'({4'd3, 1'b1, 1'b1}));
`ifdef MEMSEQ_TIMEOUT_EN
    n = 0;
    while (state_dbg == 4'd3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_len", 32'(n), 32'd15);
    @(negedge clk);
    check("timeout_err", 32'({state_dbg, err_timeout, read, busy}),
          32'({4'd11, 1'b1, 1'b0, 1'b0}));
`else
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("no_timeout", 32'({state_dbg, err_timeout, read}), 32'({4'd3, 1'b0, 1'b1}));
`endif
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr_flags", 32'({state_dbg, err_timeout, err_illegal}), 32'd0);
    clr = 1'b0;

    // Asynchronous reset in the middle of a store's write wait.
    ir_opcode = OPC_ST;
    mem_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (state_dbg != 4'd8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_t6", 32'(state_dbg), 32'd8);
    mem_ready = 1'b0;
    d0 = done_total;
    @(posedge clk); #1;
    check("t7_write", 32'({state_dbg, write}), 32'({4'd9, 1'b1}));
    clr = 1'b1;
    #1;
    check("clr_async", 32'({state_dbg, write, done, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    mem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_clr", 32'(done_total - d0), 32'd0);
    check("idle_after_clr", 32'(state_dbg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_op_sequencer

`default_nettype wire
